uart_mem_controller: RTL and testbench

- Parametrised byte-command memory engine placed between the `uart` byte interface and an internal RAM.
- Successor to the fixed-width UART memory controller: configurable address width, multi-byte address field, burst read and write, write acknowledge, ping and inter-byte timeout.
- Sits beside `uart` in a top level: consumes `received`/`rx_byte` and drives `transmit`/`tx_byte` under the `is_transmitting` handshake.

---
 rtl/uart_mem_controller.sv | 183 ++++++++++++++++++
 tb/tb_uart_mem_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_controller.sv
// Byte-command RAM engine beside a UART: write/read bursts, ping, timeout.
// Commands arrive on received/rx_byte; replies leave on transmit/tx_byte.
module uart_mem_controller #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 120000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  PING_REPLY     = 8'h21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       received,
    input  logic [7:0] rx_byte,
    input  logic       is_transmitting,
    output logic       transmit,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       error,
    output logic [7:0] cmd_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned AB    = (ADDR_W + 7) / 8;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_RFETCH, S_RLOAD, S_TXSTART, S_TXWAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        rem_q, rem_d;
    logic [1:0]        abyte_q, abyte_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              is_read_q, is_read_d;
    logic              tx_seen_q, tx_seen_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              error_q, error_d;
    logic [7:0]        cmd_count_q, cmd_count_d;
    logic              mem_we;
    logic [7:0]        rd_data_q;
    logic [7:0]        mem [DEPTH];

    always_comb begin
        // NOTE: every signal gets its default first, so no path can infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        abyte_d     = abyte_q;
        timer_d     = timer_q;
        is_read_d   = is_read_q;
        tx_seen_d   = tx_seen_q;
        tx_byte_d   = tx_byte_q;
        cmd_count_d = cmd_count_q;
        error_d     = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                abyte_d = '0;
                if (received) begin
                    unique case (rx_byte)
                        OP_WRITE, OP_READ: begin
                            is_read_d = (rx_byte == OP_READ);
                            addr_d    = '0;
                            state_d   = S_ADDR;
                        end
                        OP_PING: begin
                            is_read_d = 1'b0;
                            tx_byte_d = PING_REPLY;
                            state_d   = S_TXSTART;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end
            S_ADDR: if (received) begin
                // Shifting in big-endian drops any bits above ADDR_W.
                addr_d  = ADDR_W'({addr_q, rx_byte});
                abyte_d = abyte_q + 2'd1;
                if (abyte_q == 2'(AB - 1)) state_d = S_LEN;
            end
            S_LEN: if (received) begin
                rem_d   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                state_d = is_read_q ? S_RFETCH : S_WDATA;
            end
            S_WDATA: if (received) begin
                mem_we = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - 9'd1;
                if (rem_q == 9'd1) begin
                    tx_byte_d = ACK_BYTE;
                    state_d   = S_TXSTART;
                end
            end
            S_RFETCH: state_d = S_RLOAD;
            S_RLOAD: begin
                tx_byte_d = rd_data_q;
                rem_d     = rem_q - 9'd1;
                state_d   = S_TXSTART;
            end
            S_TXSTART: begin
                tx_seen_d = 1'b0;
                if (!is_transmitting) state_d = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (!tx_seen_q) begin
                    if (is_transmitting) tx_seen_d = 1'b1;
                end else if (!is_transmitting) begin
                    if (is_read_q && rem_q != 9'd0) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_RFETCH;
                    end else begin
                        cmd_count_d = cmd_count_q + 8'd1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving on the expiry cycle still counts, so it wins.
        if (state_q inside {S_ADDR, S_LEN, S_WDATA}) begin
            if (received) begin
                timer_d = '0;
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timer_d = '0;
                error_d = 1'b1;
                state_d = S_IDLE;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        if (received && (state_q inside {S_RFETCH, S_RLOAD, S_TXSTART, S_TXWAIT}))
            error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            abyte_q     <= '0;
            timer_q     <= '0;
            is_read_q   <= 1'b0;
            tx_seen_q   <= 1'b0;
            tx_byte_q   <= '0;
            error_q     <= 1'b0;
            cmd_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            abyte_q     <= abyte_d;
            timer_q     <= timer_d;
            is_read_q   <= is_read_d;
            tx_seen_q   <= tx_seen_d;
            tx_byte_q   <= tx_byte_d;
            error_q     <= error_d;
            cmd_count_q <= cmd_count_d;
        end
    end

    // NOTE: the RAM has no reset so it maps onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= rx_byte;
        rd_data_q <= mem[addr_q];
    end

    // Gating with is_transmitting forbids a strobe while the UART is busy.
    assign transmit  = (state_q == S_TXSTART) && !is_transmitting;
    assign tx_byte   = tx_byte_q;
    assign busy      = (state_q != S_IDLE);
    assign error     = error_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_uart_mem_controller.sv
// Randomised bench for uart_mem_controller: two instances (8- and 12-bit
// address) against a command-level RAM model and a small UART responder.
module tb_uart_mem_controller;

    localparam logic [7:0] ACK  = 8'h4B;
    localparam logic [7:0] PING = 8'h21;

    logic       clk;
    logic       rst_n    [2];
    logic       received [2];
    logic [7:0] rx_byte  [2];
    logic       is_tx    [2];
    logic       transmit [2];
    logic [7:0] tx_byte  [2];
    logic       busy     [2];
    logic       error    [2];
    logic [7:0] cmd_count[2];

    logic [7:0] ram_m [2][4096];
    logic [7:0] exp_q [2][$];
    int         cmd_m   [2];
    int         err_cnt [2];
    int         n_checks = 0;
    int         n_fail   = 0;

    uart_mem_controller #(.ADDR_W(8), .TIMEOUT_CYCLES(50)) u_dut8 (
        .clk(clk), .rst_n(rst_n[0]), .received(received[0]), .rx_byte(rx_byte[0]),
        .is_transmitting(is_tx[0]), .transmit(transmit[0]), .tx_byte(tx_byte[0]),
        .busy(busy[0]), .error(error[0]), .cmd_count(cmd_count[0])
    );

    uart_mem_controller #(.ADDR_W(12), .TIMEOUT_CYCLES(50)) u_dut12 (
        .clk(clk), .rst_n(rst_n[1]), .received(received[1]), .rx_byte(rx_byte[1]),
        .is_transmitting(is_tx[1]), .transmit(transmit[1]), .tx_byte(tx_byte[1]),
        .busy(busy[1]), .error(error[1]), .cmd_count(cmd_count[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // UART stand-in: takes each strobe, goes busy after a short delay, then idles.
    task automatic uart_model(input int k);
        logic prev = 1'b0;
        logic t;
        int   wait_c = 0;
        int   busy_c = 0;
        is_tx[k] = 1'b0;
        forever begin
            @(negedge clk);
            t = transmit[k];
            if (error[k]) err_cnt[k]++;
            if (t) begin
                check("no_back_to_back", 32'(prev), 32'd0);
                check("tx_while_busy", 32'(is_tx[k]), 32'd0);
                if (exp_q[k].size() == 0) check("unexpected_tx", 32'(tx_byte[k]), 32'h100);
                else check("tx_byte", 32'(tx_byte[k]), 32'(exp_q[k].pop_front()));
            end
            if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 0) begin
                    is_tx[k] = 1'b1;
                    busy_c = int'($urandom_range(1, 6));
                end
            end else if (busy_c > 0) begin
                busy_c--;
                if (busy_c == 0) is_tx[k] = 1'b0;
            end
            if (t) wait_c = int'($urandom_range(1, 3));
            prev = t;
        end
    endtask

    initial uart_model(0);
    initial uart_model(1);

    task automatic send_byte(input int k, input logic [7:0] b, input int gap);
        @(posedge clk);
        #1 received[k] = 1'b1;
        rx_byte[k] = b;
        @(posedge clk);
        #1 received[k] = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_cmd(input int k, input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(k, bytes[i], int'($urandom_range(0, 3)));
    endtask

    task automatic push_addr(input int k, input int raw, inout logic [7:0] q[$]);
        int ab = (k == 0) ? 1 : 2;
        for (int i = ab - 1; i >= 0; i--) q.push_back(8'((raw >> (8 * i)) & 'hFF));
    endtask

    task automatic wait_done(input int k, input string tag);
        bool_done: begin
            for (int c = 0; c < 30000; c++) begin
                @(negedge clk);
                if (!busy[k] && !is_tx[k] && exp_q[k].size() == 0) disable bool_done;
            end
            check({tag, "_timeout"}, 32'd0, 32'd1);
            exp_q[k].delete();
        end
        check({tag, "_cmd_count"}, 32'(cmd_count[k]), 32'(8'(cmd_m[k])));
    endtask

    task automatic do_write(input int k, input int raw, input int len, input logic [7:0] data[$]);
        logic [7:0] q[$];
        int dep = (k == 0) ? 256 : 4096;
        int n   = (len == 0) ? 256 : len;
        q.push_back(8'h57);
        push_addr(k, raw, q);
        q.push_back(8'(len));
        for (int i = 0; i < n; i++) begin
            q.push_back(data[i]);
            ram_m[k][(raw + i) % dep] = data[i];
        end
        exp_q[k].push_back(ACK);
        cmd_m[k]++;
        send_cmd(k, q);
        wait_done(k, "write");
    endtask

    task automatic issue_read(input int k, input int raw, input int len);
        logic [7:0] q[$];
        int dep = (k == 0) ? 256 : 4096;
        int n   = (len == 0) ? 256 : len;
        q.push_back(8'h52);
        push_addr(k, raw, q);
        q.push_back(8'(len));
        for (int i = 0; i < n; i++) exp_q[k].push_back(ram_m[k][(raw + i) % dep]);
        cmd_m[k]++;
        send_cmd(k, q);
    endtask

    task automatic do_read(input int k, input int raw, input int len);
        issue_read(k, raw, len);
        wait_done(k, "read");
    endtask

    task automatic do_ping(input int k);
        logic [7:0] q[$];
        q.push_back(8'h3F);
        exp_q[k].push_back(PING);
        cmd_m[k]++;
        send_cmd(k, q);
        wait_done(k, "ping");
    endtask

    function automatic void rand_data(input int n, output logic [7:0] d[$]);
        d = {};
        for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] d[$];
        logic [7:0] q[$];
        int e0;
        int got;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; received[k] = 1'b0; rx_byte[k] = 8'h00;
            cmd_m[k] = 0; err_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", 32'(busy[k]), 32'd0);
            check("rst_transmit", 32'(transmit[k]), 32'd0);
            check("rst_tx_byte", 32'(tx_byte[k]), 32'd0);
            check("rst_error", 32'(error[k]), 32'd0);
            check("rst_cmd_count", 32'(cmd_count[k]), 32'd0);
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit instance: basic write then read back
        d = '{8'hAA, 8'hBB, 8'hCC};
        do_write(0, 'h10, 3, d);
        do_read(0, 'h10, 3);
        check("wr_rd_cmd_count", 32'(cmd_count[0]), 32'd2);
        check("wr_rd_no_error", 32'(err_cnt[0]), 32'd0);

        // burst across the top of the address space
        d = '{8'h11, 8'h22};
        do_write(0, 'hFF, 2, d);
        do_read(0, 'hFF, 2);

        // reset between clock edges in the middle of a 3-byte read
        issue_read(0, 'h10, 3);
        got = 0;
        for (int c = 0; c < 2000 && got == 0; c++) begin
            @(negedge clk);
            if (exp_q[0].size() == 2) got = 1;
        end
        check("rst_mid_reached", 32'(got), 32'd1);
        @(posedge clk);
        #3 rst_n[0] = 1'b0;
        #1;
        check("async_busy", 32'(busy[0]), 32'd0);
        check("async_transmit", 32'(transmit[0]), 32'd0);
        check("async_error", 32'(error[0]), 32'd0);
        check("async_cmd_count", 32'(cmd_count[0]), 32'd0);
        exp_q[0].delete();
        cmd_m[0] = 0;
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        for (int c = 0; c < 50 && is_tx[0]; c++) @(negedge clk);
        do_read(0, 'h10, 3);

        // fill the whole 8-bit RAM, then protocol errors
        rand_data(256, d);
        do_write(0, 'h00, 0, d);
        e0 = err_cnt[0];
        send_byte(0, 8'h00, 0);
        repeat (4) @(negedge clk);
        check("bad_opcode_err", 32'(err_cnt[0] - e0), 32'd1);
        check("bad_opcode_idle", 32'(busy[0]), 32'd0);
        e0 = err_cnt[0];
        issue_read(0, 'h00, 2);
        got = 0;
        for (int c = 0; c < 2000 && got == 0; c++) begin
            @(negedge clk);
            if (is_tx[0]) got = 1;
        end
        check("inject_reached", 32'(got), 32'd1);
        send_byte(0, 8'h99, 0);
        wait_done(0, "inject");
        check("inject_err", 32'(err_cnt[0] - e0), 32'd1);

        // 12-bit instance: timeout, ping, wide address with length 0
        q = '{8'h57, 8'h10};
        e0 = err_cnt[1];
        send_cmd(1, q);
        repeat (60) @(negedge clk);
        check("timeout_err", 32'(err_cnt[1] - e0), 32'd1);
        check("timeout_idle", 32'(busy[1]), 32'd0);
        do_ping(1);
        check("ping_cmd_count", 32'(cmd_count[1]), 32'd1);
        rand_data(256, d);
        do_write(1, 'h005, 0, d);
        e0 = err_cnt[1];
        do_read(1, 'hF005, 0);
        check("wide_no_error", 32'(err_cnt[1] - e0), 32'd0);

        // random command mix on both instances
        for (int it = 0; it < 40; it++) begin
            int k   = it % 2;
            int op  = int'($urandom_range(0, 2));
            int len = int'($urandom_range(1, (k == 0) ? 9 : 50));
            int a   = (k == 0) ? int'($urandom_range(0, 255))
                               : (5 + int'($urandom_range(0, 200))) | (int'($urandom_range(0, 15)) << 12);
            if (k == 0 && $urandom_range(0, 9) == 0) len = 0;
            e0 = err_cnt[k];
            unique case (op)
                0: begin
                    rand_data((len == 0) ? 256 : len, d);
                    do_write(k, a, len, d);
                end
                1: do_read(k, a, len);
                default: do_ping(k);
            endcase
            check("rand_no_error", 32'(err_cnt[k] - e0), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
